// File: rtl/mem_arbiter.sv
// mem_arbiter: instruction/data requester arbiter onto one single-port memory; ARB_FAIRNESS_EN enables the data-streak fairness limit
module mem_arbiter #(
  parameter int WORD_BITWIDTH = 32,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inst_req,
  input  logic [WORD_BITWIDTH-1:0] inst_addr,
  output logic                     inst_gnt,
  output logic                     inst_rvalid,
  output logic [WORD_BITWIDTH-1:0] inst_rdata,
  input  logic                     data_req,
  input  logic                     data_we,
  input  logic [WORD_BITWIDTH-1:0] data_addr,
  input  logic [WORD_BITWIDTH-1:0] data_wdata,
  output logic                     data_gnt,
  output logic                     data_rvalid,
  output logic [WORD_BITWIDTH-1:0] data_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [WORD_BITWIDTH-1:0] mem_addr,
  output logic [WORD_BITWIDTH-1:0] mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [WORD_BITWIDTH-1:0] mem_rdata,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_nxt;
  logic owner_data, owner_nxt;
  logic pick_data;
  logic gnt;
  logic resp;
`ifdef ARB_FAIRNESS_EN
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  logic [SW-1:0] streak;
  assign pick_data = data_req && !(inst_req && streak >= SW'(MAX_DATA_STREAK));
  // Count data grants that overtook a waiting fetch; an instruction grant restarts the count
  always_ff @(posedge clk or negedge rst)
    if (!rst) streak <= '0;
    else if (inst_gnt) streak <= '0;
    else if (data_gnt && inst_req && streak != SW'(MAX_DATA_STREAK)) streak <= streak + 1'b1;
`else
  logic unused_streak;
  assign unused_streak = ^MAX_DATA_STREAK;
  assign pick_data = data_req;
`endif
  // State and owner register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      owner_data <= 1'b0;
    end else begin
      state <= state_nxt;
      owner_data <= owner_nxt;
    end
  // Next state: arbitrate in IDLE, wait for mem_gnt in ISSUE, wait for mem_rvalid in WAIT
  always_comb begin
    state_nxt = state;
    owner_nxt = owner_data;
    gnt = 1'b0;
    case (state)
      IDLE: if (inst_req || data_req) begin
        state_nxt = ISSUE;
        owner_nxt = pick_data;
      end
      ISSUE: if (mem_gnt) begin
        state_nxt = WAIT;
        gnt = 1'b1;
      end
      WAIT: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign resp = state == WAIT && mem_rvalid;
  assign busy = state != IDLE;
  assign mem_req = state == ISSUE;
  assign mem_we = mem_req && owner_data && data_we;
  assign mem_addr = !mem_req ? '0 : owner_data ? data_addr : inst_addr;
  assign mem_wdata = mem_req && owner_data ? data_wdata : '0;
  assign inst_gnt = gnt && !owner_data;
  assign data_gnt = gnt && owner_data;
  // Capture the response into the owner's port and pulse its rvalid one cycle later
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_rvalid <= resp && !owner_data;
      data_rvalid <= resp && owner_data;
      if (resp && !owner_data) inst_rdata <= mem_rdata;
      if (resp && owner_data) data_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven directed check of mem_arbiter plus reset and fairness sequences
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inst_req = 1'b0, data_req = 1'b0, data_we = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic inst_gnt, inst_rvalid, data_gnt, data_rvalid, mem_req, mem_we, busy;
  logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;
  int checks = 0, passes = 0;

  typedef struct packed {
    logic ir; logic [31:0] ia; logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic mg; logic mv; logic [31:0] md;
  } in_t;
  typedef struct packed {
    logic mr; logic mw; logic [31:0] ma; logic [31:0] mwd; logic ig; logic dg;
    logic iv; logic dv; logic [31:0] ird; logic [31:0] drd; logic b;
  } out_t;
  typedef struct { string name; in_t i; out_t o; } vec_t;
  vec_t vecs[$];

  localparam logic [31:0] DB = 32'hDEADBEEF, D1 = 32'h11111111, CF = 32'hCAFEF00D, A5 = 32'hAAAA5555;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void row(string n, logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da, logic [31:0] dd,
                              logic mg, logic mv, logic [31:0] md, logic mr, logic mw, logic [31:0] ma, logic [31:0] mwd,
                              logic ig, logic dg, logic iv, logic dv, logic [31:0] ird, logic [31:0] drd, logic b);
    vec_t v;
    v.name = n;
    v.i = '{ir, ia, dr, dw, da, dd, mg, mv, md};
    v.o = '{mr, mw, ma, mwd, ig, dg, iv, dv, ird, drd, b};
    vecs.push_back(v);
  endfunction

  function automatic out_t sample();
    return '{mem_req, mem_we, mem_addr, mem_wdata, inst_gnt, data_gnt, inst_rvalid, data_rvalid, inst_rdata, data_rdata, busy};
  endfunction

  task automatic drive(input in_t v);
    inst_req = v.ir; inst_addr = v.ia; data_req = v.dr; data_we = v.dw; data_addr = v.da; data_wdata = v.dd;
    mem_gnt = v.mg; mem_rvalid = v.mv; mem_rdata = v.md;
  endtask

  task automatic chk(input string n, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", n, act, exp);
    else passes++;
  endtask

  task automatic chk1(input string n, input logic act, input logic exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %b expected %b", n, act, exp);
    else passes++;
  endtask

  initial begin
    int grants;
    logic is_inst;
    row("rd_idle",   1,'h100,0,0,0,0,       0,0,0,           0,0,0,0,         0,0,0,0,0,0,0);
    row("rd_gnt",    1,'h100,0,0,0,0,       1,0,0,           1,0,'h100,0,     1,0,0,0,0,0,1);
    row("rd_wait",   0,0,0,0,0,0,           0,1,DB,          0,0,0,0,         0,0,0,0,0,0,1);
    row("rd_rvalid", 0,0,0,0,0,0,           0,0,0,           0,0,0,0,         0,0,1,0,DB,0,0);
    row("ct_idle",   1,'h200,1,1,'h40,'h55, 0,0,0,           0,0,0,0,         0,0,0,0,DB,0,0);
    row("ct_dgnt",   1,'h200,1,1,'h40,'h55, 1,0,0,           1,1,'h40,'h55,   0,1,0,0,DB,0,1);
    row("ct_wait",   1,'h200,0,0,0,0,       0,1,D1,          0,0,0,0,         0,0,0,0,DB,0,1);
    row("ct_b2b",    1,'h200,0,0,0,0,       0,0,0,           0,0,0,0,         0,0,0,1,DB,D1,0);
    row("ct_ignt",   1,'h200,0,1,'h44,'hFF, 1,1,'h99,        1,0,'h200,0,     1,0,0,0,DB,D1,1);
    row("ct_iwait",  0,0,0,0,0,0,           0,1,CF,          0,0,0,0,         0,0,0,0,DB,D1,1);
    row("ct_irv",    0,0,0,0,0,0,           0,1,'h12345678,  0,0,0,0,         0,0,1,0,CF,D1,0);
    row("idle_ign",  0,0,0,0,0,0,           0,0,0,           0,0,0,0,         0,0,0,0,CF,D1,0);
    row("st_idle",   0,0,1,0,'h80,'h77,     0,0,0,           0,0,0,0,         0,0,0,0,CF,D1,0);
    for (int k = 0; k < 5; k++)
      row("st_hold", 0,0,1,0,'h80,'h77,     0,0,0,           1,0,'h80,'h77,   0,0,0,0,CF,D1,1);
    row("st_gnt",    0,0,1,0,'h80,'h77,     1,0,0,           1,0,'h80,'h77,   0,1,0,0,CF,D1,1);
    row("st_wait",   0,0,0,0,0,0,           0,1,A5,          0,0,0,0,         0,0,0,0,CF,D1,1);
    row("st_rv",     0,0,0,0,0,0,           0,0,0,           0,0,0,0,         0,0,0,1,CF,A5,0);

    repeat (2) @(negedge clk);
    #2 chk("reset_state", sample(), '0);
    @(negedge clk) rst = 1'b1;
    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].i);
      #2 chk(vecs[k].name, sample(), vecs[k].o);
    end

    @(negedge clk) drive('{1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0});
    @(negedge clk) mem_gnt = 1'b1;
    @(negedge clk) begin inst_req = 1'b0; mem_gnt = 1'b0; end
    #2 chk1("rst_pre_busy", busy, 1'b1);
    rst = 1'b0;
    #1 chk("rst_async", sample(), '0);
    #1 rst = 1'b1;
    @(negedge clk) begin mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0; end
    #2 chk("rst_rvalid_drop", sample(), '0);
    @(negedge clk) mem_rvalid = 1'b0;
    #2 chk("rst_no_fwd", sample(), '0);

    drive('{1'b1, 32'h400, 1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 1'b1, 32'h0});
    grants = 0;
    for (int c = 0; c < 100 && grants < 15; c++) begin
      @(negedge clk);
      #2;
      if (inst_gnt || data_gnt) begin
`ifdef ARB_FAIRNESS_EN
        is_inst = grants % 5 == 4;
`else
        is_inst = 1'b0;
`endif
        chk1($sformatf("fair_gnt%0d", grants), inst_gnt, is_inst);
        grants++;
      end
    end
    checks++;
    if (grants != 15) $display("FAIL fair_count: got %0d grants expected 15", grants);
    else passes++;
    drive('0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_BITWIDTH, default 32, sets the address and data width.
REQ-002 Parameter MAX_DATA_STREAK, default 4, sets the consecutive data grants allowed while an instruction request waits (fairness build only).
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-low.
REQ-005 inst_req  in  1; inst_addr  in  WORD_BITWIDTH; inst_gnt  out  1; inst_rvalid  out  1; inst_rdata  out  WORD_BITWIDTH: instruction-fetch requester port.
REQ-006 data_req  in  1; data_we  in  1; data_addr  in  WORD_BITWIDTH; data_wdata  in  WORD_BITWIDTH; data_gnt  out  1; data_rvalid  out  1; data_rdata  out  WORD_BITWIDTH: load/store requester port.
REQ-007 mem_req  out  1; mem_we  out  1; mem_addr  out  WORD_BITWIDTH; mem_wdata  out  WORD_BITWIDTH; mem_gnt  in  1; mem_rvalid  in  1; mem_rdata  in  WORD_BITWIDTH: shared single-port memory.
REQ-008 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-009 FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-010 IDLE: if any request is pending, latch the winner into an owner register and go to ISSUE next cycle; otherwise stay.
REQ-011 Arbitration: data_req wins over inst_req when both are high, subject to REQ-021.
REQ-012 ISSUE: mem_req=1; mem_addr/mem_we/mem_wdata are driven from the owner's live inputs (mem_we=0, mem_wdata=0 for an instruction owner).
REQ-013 ISSUE with mem_gnt=1: assert the owner's gnt in that same cycle (combinational, one-cycle pulse), go to WAIT; with mem_gnt=0 hold ISSUE indefinitely.
REQ-014 Requesters hold req, addr, we and wdata stable from assertion until their gnt cycle; the arbiter does not check this.
REQ-015 WAIT: on mem_rvalid=1 (reads and writes both return mem_rvalid), register mem_rdata into the owner's rdata, pulse the owner's rvalid on the next cycle, and go to IDLE.
REQ-016 The non-owner's gnt and rvalid stay 0 at all times; rdata holds its last value until the next rvalid for that port.
REQ-017 Minimum latency is request seen in IDLE at cycle 0, mem_req/gnt at cycle 1, mem_rvalid at cycle 2, requester rvalid at cycle 3.
REQ-018 mem_rvalid arriving in IDLE or ISSUE is ignored.
REQ-019 A new arbitration may occur in the same cycle as the previous rvalid pulse (back-to-back throughput of one transaction per 3 cycles).

Reset
REQ-020 rst low: FSM goes to IDLE asynchronously; all outputs, the owner register, both rdata registers and the streak counter clear to 0; an in-flight transaction is abandoned and its response is never forwarded.

Configuration
REQ-021 Macro ARB_FAIRNESS_EN defined: a streak counter increments on each data gnt issued while inst_req=1 and clears on an instruction gnt. When the counter reaches MAX_DATA_STREAK, the next arbitration with inst_req=1 selects the instruction port regardless of data_req. Macro undefined: strict data priority, no counter logic.

Verification
REQ-022 Single read: inst_req, inst_addr=0x100, mem_gnt immediate, mem_rvalid next cycle with mem_rdata=0xDEADBEEF -> inst_gnt at cycle 1, inst_rvalid=1 with inst_rdata=0xDEADBEEF at cycle 3, busy high at cycles 1-2.
REQ-023 Contention: inst_req and data_req (we=1, addr=0x40, wdata=0x55) raised in the same cycle -> data served first with mem_we=1, mem_addr=0x40, mem_wdata=0x55; the instruction is served in the following transaction.
REQ-024 Stall: mem_gnt held low for 5 cycles in ISSUE -> mem_req stays high, no gnt pulses; gnt occurs in the cycle mem_gnt rises.
REQ-025 Fairness (ARB_FAIRNESS_EN, MAX_DATA_STREAK=4): data_req and inst_req held continuously -> 4 data transactions, then 1 instruction transaction, repeating; without the macro, the instruction port is never granted.
REQ-026 Reset mid-WAIT: rst pulsed low, then mem_rvalid=1 -> no rvalid on either port, busy=0, all outputs 0, FSM in IDLE.
